// File: rtl/bvudiv_inv_solver.sv
// bvudiv_inv_solver
//
// Sequential witness generator for the unsigned-division / signed-compare
// invertibility problem. For each accepted request (s, t) it walks candidate
// x = 0, 1, ..., 2^W-1 and reports the first x that satisfies
//   MODE 0: (x udiv s) >=s t
//   MODE 1: (s udiv x) >=s t
// Each candidate is divided with a W-step restoring divider (one quotient bit
// per cycle), then checked in one extra cycle, so every candidate costs W+1
// cycles regardless of the operand values.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, returns to IDLE
//   in_valid   : request valid
//   in_ready   : solver idle, request will be accepted
//   in_s       : operand s (unsigned), sampled only at acceptance
//   in_t       : bound t (two's complement), sampled only at acceptance
//   out_valid  : result valid, held until out_ready
//   out_ready  : consumer accepts the result
//   out_x      : minimal witness, 0 when no witness exists
//   out_found  : a satisfying x exists
module bvudiv_inv_solver #(
    parameter int W    = 4,
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_t,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_x,
    output logic         out_found
);

    localparam int SW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic        [W-1:0]  s_q, s_d;
    logic signed [W-1:0]  t_q, t_d;
    logic        [W-1:0]  x_q, x_d;
    logic        [W-1:0]  rem_q, rem_d;
    logic        [W-1:0]  quo_q, quo_d;
    logic        [SW-1:0] step_q, step_d;
    logic        [W-1:0]  out_x_q, out_x_d;
    logic                 found_q, found_d;

    // Divider datapath: dividend/divisor roles swap with MODE.
    logic        [W-1:0]  dividend;
    logic        [W-1:0]  divisor;
    logic        [W:0]    trial;
    logic                 take;
    logic signed [W-1:0]  quo_sgn;
    logic                 sat;

    always_comb begin
        if (MODE == 0) begin
            dividend = x_q;
            divisor  = s_q;
        end else begin
            dividend = s_q;
            divisor  = x_q;
        end
        // Shift the next dividend bit into the partial remainder. With a zero
        // divisor the trial always "fits", so the quotient becomes all-ones
        // without any special case.
        trial   = {rem_q, dividend[step_q]};
        take    = (trial >= {1'b0, divisor});
        quo_sgn = quo_q;
        sat     = (quo_sgn >= t_q);
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        t_d     = t_q;
        x_d     = x_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        step_d  = step_q;
        out_x_d = out_x_q;
        found_d = found_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    s_d     = in_s;
                    t_d     = in_t;
                    x_d     = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                    step_d  = SW'(W - 1);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // Remainder stays below the divisor, so it always fits W bits.
                rem_d  = take ? W'(trial - {1'b0, divisor}) : trial[W-1:0];
                quo_d  = {quo_q[W-2:0], take};
                step_d = step_q - SW'(1);
                if (step_q == '0) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (sat) begin
                    out_x_d = x_q;
                    found_d = 1'b1;
                    state_d = S_DONE;
                end else if (x_q == '1) begin
                    // Terminal candidate detected before incrementing, so
                    // the candidate counter never wraps.
                    out_x_d = '0;
                    found_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    x_d     = x_q + W'(1);
                    rem_d   = '0;
                    quo_d   = '0;
                    step_d  = SW'(W - 1);
                    state_d = S_DIV;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            t_q     <= '0;
            x_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            step_q  <= '0;
            out_x_q <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            t_q     <= t_d;
            x_q     <= x_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            step_q  <= step_d;
            out_x_q <= out_x_d;
            found_q <= found_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_x     = out_x_q;
    assign out_found = found_q;

endmodule

// File: tb/tb_bvudiv_inv_solver.sv
// Testbench for bvudiv_inv_solver: four instances (W=4/5, MODE=0/1) driven
// one at a time; expected results come from a behavioural search model and
// are queued when a request is issued, then popped when out_valid appears.
module tb_bvudiv_inv_solver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] s_drv;
    logic [4:0] t_drv;
    logic       iv[4];
    logic       ordy[4];
    logic       ir[4];
    logic       ov[4];
    logic       of_[4];
    logic [3:0] ox4[2];
    logic [4:0] ox5[2];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int idx;
        int x;
        int found;
        int lat;
    } exp_t;

    exp_t sb[$];

    bvudiv_inv_solver #(.W(4), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_s(s_drv[3:0]), .in_t(t_drv[3:0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_x(ox4[0]), .out_found(of_[0]));
    bvudiv_inv_solver #(.W(4), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_s(s_drv[3:0]), .in_t(t_drv[3:0]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_x(ox4[1]), .out_found(of_[1]));
    bvudiv_inv_solver #(.W(5), .MODE(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_s(s_drv), .in_t(t_drv), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_x(ox5[0]), .out_found(of_[2]));
    bvudiv_inv_solver #(.W(5), .MODE(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_s(s_drv), .in_t(t_drv), .out_valid(ov[3]),
        .out_ready(ordy[3]), .out_x(ox5[1]), .out_found(of_[3]));

    function automatic int wid(input int idx);
        return (idx < 2) ? 4 : 5;
    endfunction

    function automatic int mode_of(input int idx);
        return idx % 2;
    endfunction

    function automatic int getx(input int idx);
        case (idx)
            0:       return int'(ox4[0]);
            1:       return int'(ox4[1]);
            2:       return int'(ox5[0]);
            default: return int'(ox5[1]);
        endcase
    endfunction

    // Minimal unsigned x with SMT-LIB udiv (x/0 = all-ones) and signed compare.
    function automatic void model(input int md, input int w, input int s,
                                  input int t, output bit f, output int xr);
        int mask;
        int n;
        int d;
        int q;
        int qs;
        int ts;
        mask = (1 << w) - 1;
        ts   = (t >= (1 << (w - 1))) ? t - (1 << w) : t;
        f    = 1'b0;
        xr   = 0;
        for (int x = 0; x <= mask; x++) begin
            n  = (md == 0) ? x : s;
            d  = (md == 0) ? s : x;
            q  = (d == 0) ? mask : n / d;
            qs = (q >= (1 << (w - 1))) ? q - (1 << w) : q;
            if (!f && qs >= ts) begin
                f  = 1'b1;
                xr = x;
            end
        end
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Issue one request on instance idx (called at a falling edge), wait for
    // the result, optionally hold off out_ready for 'hold' cycles, then
    // complete the handshake.
    task automatic run(input int idx, input int s, input int t, input int hold);
        int   w;
        int   x;
        int   cyc;
        int   limit;
        bit   f;
        exp_t e;
        exp_t got;
        w = wid(idx);
        model(mode_of(idx), w, s, t, f, x);
        e.idx   = idx;
        e.found = f ? 1 : 0;
        e.x     = f ? x : 0;
        e.lat   = f ? (x + 1) * (w + 1) + 1 : (1 << w) * (w + 1) + 1;
        sb.push_back(e);

        s_drv   = 5'(s);
        t_drv   = 5'(t);
        iv[idx] = 1'b1;
        chk("in_ready_idle", int'(ir[idx]), 1);
        @(negedge clk);
        // cycle 1: inputs change freely from here on
        iv[idx] = 1'b0;
        s_drv   = 5'($urandom);
        t_drv   = 5'($urandom);
        chk("in_ready_busy", int'(ir[idx]), 0);
        cyc   = 1;
        limit = (1 << w) * (w + 1) + 20;
        while (!ov[idx] && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        got = sb.pop_front();
        chk("latency", cyc, got.lat);
        chk("out_found", int'(of_[idx]), got.found);
        chk("out_x", getx(idx), got.x);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(ov[idx]), 1);
            chk("hold_x", getx(idx), got.x);
            chk("hold_found", int'(of_[idx]), got.found);
            chk("hold_in_ready", int'(ir[idx]), 0);
        end
        ordy[idx] = 1'b1;
        @(negedge clk);
        ordy[idx] = 1'b0;
        chk("in_ready_after", int'(ir[idx]), 1);
        chk("valid_after", int'(ov[idx]), 0);
    endtask

    initial begin
        rst   = 1'b1;
        s_drv = '0;
        t_drv = '0;
        for (int i = 0; i < 4; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_in_ready", int'(ir[i]), 1);
            chk("rst_out_valid", int'(ov[i]), 0);
            chk("rst_out_x", getx(i), 0);
            chk("rst_out_found", int'(of_[i]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed W=4 cases
        run(0, 1, 0, 0);      // minimal witness x=0, cycle 6
        run(0, 1, 7, 20);     // signed boundary x=7, cycle 41, backpressure

        // Reset in the middle of a search; previous out_x=7 must not survive
        s_drv = 5'd0;
        t_drv = 5'd0;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        chk("mid_in_ready_busy", int'(ir[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", int'(ir[0]), 1);
        chk("midrst_out_valid", int'(ov[0]), 0);
        chk("midrst_out_x", getx(0), 0);
        chk("midrst_out_found", int'(of_[0]), 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_quiet", int'(ov[0]), 0);
        end

        run(0, 0, 0, 0);      // unsatisfiable, cycle 81
        run(1, 6, 3, 0);      // x=0 divides by zero and fails, x=1 at cycle 11
        run(1, 6, 8, 0);      // t=-8, x=0 at cycle 6

        // Exhaustive W=4 sweep, both modes
        for (int idx = 0; idx < 2; idx++) begin
            for (int s = 0; s < 16; s++) begin
                for (int t = 0; t < 16; t++) begin
                    run(idx, s, t, 0);
                end
            end
        end

        // W=5: corners plus random pairs, both modes
        for (int idx = 2; idx < 4; idx++) begin
            run(idx, 0, 0, 0);
            run(idx, 31, 15, 0);
            run(idx, 1, 16, 0);
            run(idx, 0, 31, 0);
            for (int k = 0; k < 32; k++) begin
                run(idx, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
